// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and constants for the button press classifier
package button_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_HELD   = 3'd4
    } state_t;

    // Default timing at a 100 MHz clock.
    localparam int unsigned LONG_TIME_DEF   = 100_000_000;
    localparam int unsigned DOUBLE_GAP_DEF  = 30_000_000;
    localparam int unsigned REPEAT_TIME_DEF = 20_000_000;
    localparam int          CW_DEF          = 27;

    // Event codes for the top-level control mux.
    localparam logic [2:0] EV_NONE   = 3'd0;
    localparam logic [2:0] EV_SHORT  = 3'd1;
    localparam logic [2:0] EV_DOUBLE = 3'd2;
    localparam logic [2:0] EV_LONG   = 3'd3;
    localparam logic [2:0] EV_REPEAT = 3'd4;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising/falling edge detector on a synchronous level
module edge_detect #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise,
    output logic fall
);

    logic prev;

    // Track the previous sample; INIT=1 hides a level already high at reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= INIT;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;
    assign fall = ~in & prev;

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - short/double/long press and auto-repeat classifier
module button_press_classifier
    import button_pkg::*;
#(
    parameter int unsigned LONG_TIME   = LONG_TIME_DEF,
    parameter int unsigned DOUBLE_GAP  = DOUBLE_GAP_DEF,
    parameter int unsigned REPEAT_TIME = REPEAT_TIME_DEF,
    parameter int          CW          = CW_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btn,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TIME - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(DOUBLE_GAP - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TIME - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fall;

    edge_detect #(
        .INIT (1'b1)
    ) u_edge (
        .clk   (clk),
        .reset (reset),
        .in    (btn),
        .rise  (rise),
        .fall  (fall)
    );

    // Gesture FSM with its cycle counter and registered one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            if (!enable) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt <= '0;
                        if (rise) begin
                            state <= S_PRESS1;
                        end
                    end
                    S_PRESS1: begin
                        // A release on the timeout edge still counts as a short press.
                        if (fall) begin
                            state <= S_WAIT2;
                            cnt   <= '0;
                        end else if (cnt == LONG_LAST && btn) begin
                            long_press <= 1'b1;
                            state      <= S_HELD;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_WAIT2: begin
                        // A second press on the timeout edge still counts as a double press.
                        if (rise) begin
                            double_press <= 1'b1;
                            state        <= S_PRESS2;
                            cnt          <= '0;
                        end else if (cnt == GAP_LAST) begin
                            short_press <= 1'b1;
                            state       <= S_IDLE;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_PRESS2: begin
                        cnt <= '0;
                        if (fall) begin
                            state <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        if (fall) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (cnt == REPEAT_LAST) begin
                            repeat_pulse <= 1'b1;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
